present_round_datapath: RTL and testbench

Iterative PRESENT-80 round datapath. It consumes the stream of 64-bit round keys produced by the key-schedule stage and turns one 64-bit plaintext into ciphertext. Each accepted key performs one round: addRoundKey, sLayer, pLayer. The last key performs only the final addRoundKey. It sits directly downstream of the round-key generator in the encrypt path, replacing the stub sbox stage that follows key generation.

---
 rtl/present_round_datapath.sv | 135 +++++++++++++
 tb/tb_present_round_datapath.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/present_round_datapath.sv
// Iterative PRESENT-80 round datapath: one round per accepted round key, final
// key does whitening only. Sixteen S-box lanes feed a hard-wired bit permutation.

module present_sbox4 (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);
  always_comb begin
    nib_o = 4'h0;
    unique case (nib_i)
      4'h0: nib_o = 4'hC;
      4'h1: nib_o = 4'h5;
      4'h2: nib_o = 4'h6;
      4'h3: nib_o = 4'hB;
      4'h4: nib_o = 4'h9;
      4'h5: nib_o = 4'h0;
      4'h6: nib_o = 4'hA;
      4'h7: nib_o = 4'hD;
      4'h8: nib_o = 4'h3;
      4'h9: nib_o = 4'hE;
      4'hA: nib_o = 4'hF;
      4'hB: nib_o = 4'h8;
      4'hC: nib_o = 4'h4;
      4'hD: nib_o = 4'h7;
      4'hE: nib_o = 4'h1;
      4'hF: nib_o = 4'h2;
      default: nib_o = 4'h0;
    endcase
  end
endmodule

module present_round_datapath #(
  parameter int ROUNDS    = 31,
  parameter int NUM_LANES = 16,
  parameter int VEC_W     = 4
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic        start_i,
  input  logic [63:0] plaintext_i,
  input  logic [63:0] round_key_i,
  input  logic        key_valid_i,
  output logic        key_ready_o,
  output logic        busy_o,
  output logic [5:0]  round_count_o,
  output logic [63:0] ciphertext_o,
  output logic        done_o
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} fsm_e;

  fsm_e        fsm_q, fsm_d;
  logic [63:0] state_q, state_d;
  logic [63:0] ct_q, ct_d;
  logic [5:0]  rc_q, rc_d;
  logic        done_q, done_d;

  logic [63:0] ark;
  logic [NUM_LANES-1:0][VEC_W-1:0] sub;
  logic [63:0] perm;
  logic        hs;

  assign ark = state_q ^ round_key_i;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    present_sbox4 u_sbox (
      .nib_i (ark[VEC_W*l +: VEC_W]),
      .nib_o (sub[l])
    );
  end

  // pLayer: bit i lands at (16*i) mod 63, bit 63 is fixed.
  for (genvar i = 0; i < 63; i++) begin : g_perm
    assign perm[(16*i) % 63] = sub[i/VEC_W][i%VEC_W];
  end
  assign perm[63] = sub[NUM_LANES-1][VEC_W-1];

  // Ready depends only on state so it never loops back through key_valid.
  assign key_ready_o   = (fsm_q != S_IDLE);
  assign busy_o        = key_ready_o;
  assign hs            = key_valid_i & key_ready_o;
  assign round_count_o = rc_q;
  assign ciphertext_o  = ct_q;
  assign done_o        = done_q;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    ct_d    = ct_q;
    rc_d    = rc_q;
    done_d  = 1'b0;
    unique case (fsm_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = plaintext_i;
          rc_d    = 6'd1;
          fsm_d   = S_ROUND;
        end
      end
      S_ROUND: begin
        if (hs) begin
          state_d = perm;
          rc_d    = rc_q + 6'd1;
          if (rc_q == 6'(ROUNDS)) fsm_d = S_FINAL;
        end
      end
      S_FINAL: begin
        if (hs) begin
          ct_d   = ark;
          done_d = 1'b1;
          rc_d   = 6'd0;
          fsm_d  = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      ct_q    <= '0;
      rc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      ct_q    <= ct_d;
      rc_q    <= rc_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_present_round_datapath.sv
// Random and directed checks of the PRESENT round datapath against a
// loop-level cipher model fed by a PRESENT-80 key-schedule model.

module tb_present_round_datapath;
  localparam int ROUNDS = 31;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] plaintext = '0;
  logic [63:0] round_key = '0;
  logic        key_valid = 1'b0;
  logic        key_ready, busy, done;
  logic [5:0]  round_count;
  logic [63:0] ciphertext;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0]  SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [63:0] rk [ROUNDS+1];

  present_round_datapath #(.ROUNDS(ROUNDS)) dut (
    .clock_i       (clock),
    .reset_n_i     (reset_n),
    .start_i       (start),
    .plaintext_i   (plaintext),
    .round_key_i   (round_key),
    .key_valid_i   (key_valid),
    .key_ready_o   (key_ready),
    .busy_o        (busy),
    .round_count_o (round_count),
    .ciphertext_o  (ciphertext),
    .done_o        (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sub64(input logic [63:0] x);
    logic [63:0] r;
    for (int k = 0; k < 16; k++) r[4*k +: 4] = SB[x[4*k +: 4]];
    return r;
  endfunction

  function automatic logic [63:0] perm64(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 63; i++) r[(16*i) % 63] = x[i];
    r[63] = x[63];
    return r;
  endfunction

  task automatic gen_keys(input logic [79:0] key);
    logic [79:0] k;
    k = key;
    for (int r = 0; r <= ROUNDS; r++) begin
      rk[r] = k[79:16];
      k = {k[18:0], k[79:19]};
      k[79:76] = SB[k[79:76]];
      k[19:15] = k[19:15] ^ 5'(r + 1);
    end
  endtask

  function automatic logic [63:0] model(input logic [63:0] pt);
    logic [63:0] s;
    s = pt;
    for (int r = 0; r < ROUNDS; r++) s = perm64(sub64(s ^ rk[r]));
    return s ^ rk[ROUNDS];
  endfunction

  // Entered and left at a negedge; on return the done cycle is current.
  task automatic run_block(input logic [79:0] key, input logic [63:0] pt,
                           input bit stall, input bit spam);
    logic [63:0] exp;
    int idx, cycles, stalls;
    bit got_done, kv;
    gen_keys(key);
    exp = model(pt);
    start = 1'b1; plaintext = pt; key_valid = 1'b0;
    @(posedge clock); @(negedge clock);
    start = 1'b0;
    chk("done_low_after_start", 64'(done), 64'(0));
    idx = 0; cycles = 0; stalls = 0; got_done = 0;
    while (!got_done && cycles < 400) begin
      chk("key_ready_busy", 64'(key_ready), 64'(1));
      chk("round_count", 64'(round_count), 64'(idx + 1));
      kv = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      key_valid = kv;
      round_key = (idx <= ROUNDS) ? rk[idx] : 64'h0;
      start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      if (!kv) stalls++;
      @(posedge clock);
      if (kv) idx++;
      @(negedge clock);
      cycles++;
      if (done) got_done = 1;
    end
    start = 1'b0; key_valid = 1'b0;
    chk("done_seen", 64'(got_done), 64'(1));
    chk("handshakes", 64'(idx), 64'(ROUNDS + 1));
    chk("latency", 64'(cycles), 64'(ROUNDS + 1 + stalls));
    chk("ciphertext_model", ciphertext, exp);
    chk("round_count_idle", 64'(round_count), 64'(0));
    chk("busy_idle", 64'(busy), 64'(0));
  endtask

  initial begin
    logic [63:0] ct_hold;
    #1;
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_ct", ciphertext, 64'(0));
    chk("rst_rc", 64'(round_count), 64'(0));
    chk("rst_ready", 64'(key_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);

    run_block(80'h0, 64'h0, 0, 0);
    chk("vec_zero", ciphertext, 64'h5579C1387B228445);
    @(negedge clock);
    chk("done_one_cycle", 64'(done), 64'(0));

    run_block({80{1'b1}}, 64'h0, 1, 0);
    chk("vec_ones_stall", ciphertext, 64'hE72C46C0F5945049);
    @(negedge clock);

    run_block(80'h0, {64{1'b1}}, 0, 0);
    chk("b2b_blk1", ciphertext, 64'hA112FFC72F68417B);
    run_block({80{1'b1}}, {64{1'b1}}, 0, 0);
    chk("b2b_blk2", ciphertext, 64'h3333DCD3213210D2);
    @(negedge clock);
    chk("b2b_done_low", 64'(done), 64'(0));

    run_block({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom}, 1, 1);
    @(negedge clock);
    chk("spam_single_done", 64'(done), 64'(0));
    chk("spam_idle", 64'(busy), 64'(0));

    ct_hold = ciphertext;
    key_valid = 1'b1; round_key = {$urandom, $urandom};
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      chk("idle_ready", 64'(key_ready), 64'(0));
      chk("idle_rc", 64'(round_count), 64'(0));
      chk("idle_ct", ciphertext, ct_hold);
      chk("idle_done", 64'(done), 64'(0));
    end
    key_valid = 1'b0;

    gen_keys({$urandom, $urandom, 16'($urandom)});
    start = 1'b1; plaintext = {$urandom, $urandom};
    @(posedge clock); @(negedge clock);
    start = 1'b0; key_valid = 1'b1;
    for (int r = 0; r < 10; r++) begin
      round_key = rk[r];
      @(posedge clock);
    end
    #1;
    chk("rc_before_reset", 64'(round_count), 64'(11));
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_ready", 64'(key_ready), 64'(0));
    chk("mid_rst_rc", 64'(round_count), 64'(0));
    chk("mid_rst_ct", ciphertext, 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    key_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("rst_hold_done", 64'(done), 64'(0));
    end
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_done", 64'(done), 64'(0));
    run_block(80'h0, 64'h0, 0, 0);
    chk("post_rst_vec", ciphertext, 64'h5579C1387B228445);
    @(negedge clock);

    for (int b = 0; b < 4; b++) begin
      run_block({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom}, 1, b[0]);
      if (b[1]) @(negedge clock);
    end
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
